mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, placed between the EX/MEM latch and the write-back stage. It owns the byte-addressable data memory and performs byte/halfword/word loads and stores with sign or zero extension. It also contains the MEM/WB pipeline register that feeds write-back, and a debug read port for the debug unit.

## Interface
- NB_DATA, 32, data and ALU result width
- NB_REG, 5, register index width
- NB_PC, 32, PC width
- NB_ADDR, 8, word-address width (memory depth 2^NB_ADDR words)

Ports:
- i_clock  in  1  pipeline clock
- i_reset  in  1  asynchronous, active-low reset
- i_MEM_enable  in  1  pipeline advance from the debug unit; 0 = freeze
- i_MEM_reg_write  in  1  passed to WB
- i_MEM_mem_to_reg  in  1  passed to WB
- i_MEM_mem_read  in  1  load instruction
- i_MEM_mem_write  in  1  store instruction
- i_MEM_size  in  2  access size (package encoding)
- i_MEM_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- i_MEM_alu_result  in  NB_DATA  byte address; also passed to WB
- i_MEM_write_data  in  NB_DATA  store data (rt)
- i_MEM_selected_reg  in  NB_REG  destination register
- i_MEM_r31_ctrl  in  1  JAL/JALR link select
- i_MEM_pc  in  NB_PC  return address for link
- i_MEM_halt  in  1  HALT marker
- i_MEM_debug_addr  in  NB_ADDR  debug word address
- o_MEM_debug_data  out  NB_DATA  raw word at debug address
- o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_halt  out  1  latched controls
- o_WB_mem_data  out  NB_DATA  extended load data
- o_WB_alu_result  out  NB_DATA  latched ALU result
- o_WB_selected_reg  out  NB_REG  latched destination
- o_WB_pc  out  NB_PC  latched PC

## Operation
- Word index is alu_result[NB_ADDR+1:2], lane is alu_result[1:0]; address bits above NB_ADDR+1 are ignored.
- Alignment is forced: halfword ignores bit 0; word ignores bits [1:0]. No misalignment exception.
- Store (mem_write & enable): byte writes write_data[7:0] to lane alu_result[1:0]; half writes [15:0] to lane pair alu_result[1]; word writes all 4 bytes. Other bytes are unchanged.
- Load: select the lane from the addressed word and extend to 32 bits by i_MEM_unsigned. When mem_read = 0, o_WB_mem_data latches 0.
- Reserved size code 2'b10 behaves as word.
- mem_read and mem_write both 1 is illegal; the store is performed and the latched load data is the pre-store word.
- Debug port: combinational read of the raw word, independent of enable.

## Timing
- Memory write is synchronous on the rising edge. Memory read is combinational.
- MEM/WB latch: 1-cycle latency. Inputs sampled at edge N appear on o_WB_* after edge N.
- enable = 0: latch holds, no memory write, debug read still live.
- Store in cycle N followed by a load of the same address in cycle N+1 returns the new data.
- Debug read of an address being stored in the same cycle shows the old value until the edge.
- Reset asserted: all o_WB_* = 0 immediately. A store pending at that edge is not performed. Memory contents are not reset.
- Reset deasserted: the first edge with enable = 1 loads the latch normally.

## Structure
- Shared package (mips_pkg): size encodings SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b11.
- One sub-module, data_mem: 2^NB_ADDR × 32 memory with 4 byte-write enables, synchronous write, two combinational read ports (pipeline, debug).
- Lane select, extension and the latch stay in mem_stage.

## Test plan
- Reset: hold i_reset = 0 with inputs nonzero -> all o_WB_* = 0; release, enable = 1 -> next edge latches inputs.
- Word store/load: SW 0xDEADBEEF @0x10, then LW @0x10 -> o_WB_mem_data = 0xDEADBEEF one cycle after the load.
- Byte lanes:
  - SB 0x80 @0x13 onto word 0 -> debug @4 = 0x80000000.
  - LB @0x13 -> 0xFFFFFF80.
  - LBU @0x13 -> 0x00000080.
- Halfword: SH 0x1234F00D @0x22 onto word 0 -> debug @8 = 0xF00D0000; LH @0x23 (forced to 0x22) -> 0xFFFFF00D.
- Freeze: enable = 0 while SW 0x55 @0x30 is presented -> memory unchanged and outputs held; enable = 1 -> write occurs and latch advances.
- Link passthrough: r31_ctrl = 1, pc = 0x40, reg = 31, halt = 1 -> o_WB_pc = 0x40, o_WB_selected_reg = 31, o_WB_halt = 1 after one edge.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline memory stage.
//   mem_size_e : load/store access-size encoding carried down the pipeline.
//   store_be   : byte-write-enable mask for a store of a given size and lane.
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_RSVD = 2'b10,   // decoded exactly like a word access
      SIZE_WORD = 2'b11
   } mem_size_e;

   localparam int NB_LANES = 4;

   // Byte enables for a store. The halfword ignores lane bit 0 and the word
   // ignores both lane bits, so misaligned addresses are silently aligned.
   function automatic logic [NB_LANES-1:0] store_be(input logic [1:0] size,
                                                    input logic [1:0] lane);
      logic [NB_LANES-1:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << lane;
         SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Word-organised data memory, 2^NB_ADDR words of NB_DATA bits, split into
// independent byte lanes so each lane maps to its own RAM column.
// Ports:
//   i_clock    write clock
//   i_we       write strobe (already qualified by enable and reset)
//   i_be       per-byte write enables
//   i_waddr    word address shared by write and pipeline read
//   i_wdata    write data, already steered onto the enabled lanes
//   o_rdata    combinational pipeline read of i_waddr
//   i_dbg_addr debug word address
//   o_dbg_data combinational debug read
// Contents are never reset.
// -----------------------------------------------------------------------------
module data_mem
   import mips_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 8
) (
   input  logic                 i_clock,
   input  logic                 i_we,
   input  logic [NB_LANES-1:0]  i_be,
   input  logic [NB_ADDR-1:0]   i_waddr,
   input  logic [NB_DATA-1:0]   i_wdata,
   output logic [NB_DATA-1:0]   o_rdata,
   input  logic [NB_ADDR-1:0]   i_dbg_addr,
   output logic [NB_DATA-1:0]   o_dbg_data
);

   localparam int DEPTH = 1 << NB_ADDR;

   genvar gi;
   generate
      for (gi = 0; gi < NB_LANES; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];

         always_ff @(posedge i_clock) begin
            if (i_we && i_be[gi]) begin
               lane_mem[i_waddr] <= i_wdata[8*gi +: 8];
            end
         end

         // Both reads see the pre-edge contents; a same-cycle store shows up
         // only after the clock edge.
         assign o_rdata[8*gi +: 8]    = lane_mem[i_waddr];
         assign o_dbg_data[8*gi +: 8] = lane_mem[i_dbg_addr];
      end
   endgenerate

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the five-stage MIPS pipeline: byte/half/word loads
// and stores against the data memory, plus the MEM/WB pipeline register.
// Ports:
//   i_clock, i_reset (async, active low)
//   i_MEM_enable          pipeline advance; 0 freezes latch and memory
//   i_MEM_* controls      reg_write, mem_to_reg, mem_read, mem_write, size,
//                         unsigned, r31_ctrl, halt
//   i_MEM_alu_result      byte address / ALU result
//   i_MEM_write_data      store data
//   i_MEM_selected_reg    destination register
//   i_MEM_pc              link return address
//   i_MEM_debug_addr      debug word address -> o_MEM_debug_data (raw word)
//   o_WB_*                latched outputs feeding write-back
// -----------------------------------------------------------------------------
module mem_stage
   import mips_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int NB_PC   = 32,
   parameter int NB_ADDR = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_MEM_enable,
   input  logic               i_MEM_reg_write,
   input  logic               i_MEM_mem_to_reg,
   input  logic               i_MEM_mem_read,
   input  logic               i_MEM_mem_write,
   input  logic [1:0]         i_MEM_size,
   input  logic               i_MEM_unsigned,
   input  logic [NB_DATA-1:0] i_MEM_alu_result,
   input  logic [NB_DATA-1:0] i_MEM_write_data,
   input  logic [NB_REG-1:0]  i_MEM_selected_reg,
   input  logic               i_MEM_r31_ctrl,
   input  logic [NB_PC-1:0]   i_MEM_pc,
   input  logic               i_MEM_halt,
   input  logic [NB_ADDR-1:0] i_MEM_debug_addr,
   output logic [NB_DATA-1:0] o_MEM_debug_data,
   output logic               o_WB_reg_write,
   output logic               o_WB_mem_to_reg,
   output logic               o_WB_r31_ctrl,
   output logic               o_WB_halt,
   output logic [NB_DATA-1:0] o_WB_mem_data,
   output logic [NB_DATA-1:0] o_WB_alu_result,
   output logic [NB_REG-1:0]  o_WB_selected_reg,
   output logic [NB_PC-1:0]   o_WB_pc
);

   logic [NB_ADDR-1:0]  word_addr;
   logic [1:0]          lane;
   logic                mem_we;
   logic [NB_LANES-1:0] mem_be;
   logic [NB_DATA-1:0]  mem_wdata;
   logic [NB_DATA-1:0]  mem_rdata;
   logic [NB_DATA-1:0]  load_ext;
   logic [7:0]          load_byte;
   logic [15:0]         load_half;

   // Upper address bits beyond the memory depth are simply dropped.
   assign word_addr = i_MEM_alu_result[NB_ADDR+1:2];
   assign lane      = i_MEM_alu_result[1:0];

   // Gating with i_reset keeps a store coinciding with reset from landing.
   assign mem_we = i_MEM_mem_write & i_MEM_enable & i_reset;
   assign mem_be = store_be(i_MEM_size, lane);

   // Replicate the store data so every lane the enables select sees its bytes.
   always_comb begin
      mem_wdata = i_MEM_write_data;
      case (i_MEM_size)
         SIZE_BYTE: mem_wdata = {4{i_MEM_write_data[7:0]}};
         SIZE_HALF: mem_wdata = {2{i_MEM_write_data[15:0]}};
         default:   mem_wdata = i_MEM_write_data;
      endcase
   end

   data_mem #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR)
   ) u_data_mem (
      .i_clock    (i_clock),
      .i_we       (mem_we),
      .i_be       (mem_be),
      .i_waddr    (word_addr),
      .i_wdata    (mem_wdata),
      .o_rdata    (mem_rdata),
      .i_dbg_addr (i_MEM_debug_addr),
      .o_dbg_data (o_MEM_debug_data)
   );

   // Lane select and extension. With read+write together the combinational
   // read still returns the pre-store word, which is what gets latched.
   always_comb begin
      load_byte = mem_rdata[{lane, 3'b000} +: 8];
      load_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext  = mem_rdata;
      case (i_MEM_size)
         SIZE_BYTE: load_ext = i_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, load_byte}
                                              : {{(NB_DATA-8){load_byte[7]}}, load_byte};
         SIZE_HALF: load_ext = i_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, load_half}
                                              : {{(NB_DATA-16){load_half[15]}}, load_half};
         default:   load_ext = mem_rdata;
      endcase
      if (!i_MEM_mem_read) begin
         load_ext = '0;
      end
   end

   // MEM/WB pipeline register
   logic               reg_write_q,  reg_write_d;
   logic               mem_to_reg_q, mem_to_reg_d;
   logic               r31_ctrl_q,   r31_ctrl_d;
   logic               halt_q,       halt_d;
   logic [NB_DATA-1:0] mem_data_q,   mem_data_d;
   logic [NB_DATA-1:0] alu_result_q, alu_result_d;
   logic [NB_REG-1:0]  sel_reg_q,    sel_reg_d;
   logic [NB_PC-1:0]   pc_q,         pc_d;

   assign reg_write_d  = i_MEM_reg_write;
   assign mem_to_reg_d = i_MEM_mem_to_reg;
   assign r31_ctrl_d   = i_MEM_r31_ctrl;
   assign halt_d       = i_MEM_halt;
   assign mem_data_d   = load_ext;
   assign alu_result_d = i_MEM_alu_result;
   assign sel_reg_d    = i_MEM_selected_reg;
   assign pc_d         = i_MEM_pc;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         r31_ctrl_q   <= 1'b0;
         halt_q       <= 1'b0;
         mem_data_q   <= '0;
         alu_result_q <= '0;
         sel_reg_q    <= '0;
         pc_q         <= '0;
      end else if (i_MEM_enable) begin
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         r31_ctrl_q   <= r31_ctrl_d;
         halt_q       <= halt_d;
         mem_data_q   <= mem_data_d;
         alu_result_q <= alu_result_d;
         sel_reg_q    <= sel_reg_d;
         pc_q         <= pc_d;
      end
   end

   assign o_WB_reg_write    = reg_write_q;
   assign o_WB_mem_to_reg   = mem_to_reg_q;
   assign o_WB_r31_ctrl     = r31_ctrl_q;
   assign o_WB_halt         = halt_q;
   assign o_WB_mem_data     = mem_data_q;
   assign o_WB_alu_result   = alu_result_q;
   assign o_WB_selected_reg = sel_reg_q;
   assign o_WB_pc           = pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage: reset, word/byte/half accesses, freeze,
// link passthrough and the corner cases of the address and size decode.
// -----------------------------------------------------------------------------
module tb_mem_stage;
   import mips_pkg::*;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_MEM_enable;
   logic        i_MEM_reg_write;
   logic        i_MEM_mem_to_reg;
   logic        i_MEM_mem_read;
   logic        i_MEM_mem_write;
   logic [1:0]  i_MEM_size;
   logic        i_MEM_unsigned;
   logic [31:0] i_MEM_alu_result;
   logic [31:0] i_MEM_write_data;
   logic [4:0]  i_MEM_selected_reg;
   logic        i_MEM_r31_ctrl;
   logic [31:0] i_MEM_pc;
   logic        i_MEM_halt;
   logic [7:0]  i_MEM_debug_addr;
   logic [31:0] o_MEM_debug_data;
   logic        o_WB_reg_write;
   logic        o_WB_mem_to_reg;
   logic        o_WB_r31_ctrl;
   logic        o_WB_halt;
   logic [31:0] o_WB_mem_data;
   logic [31:0] o_WB_alu_result;
   logic [4:0]  o_WB_selected_reg;
   logic [31:0] o_WB_pc;

   int errors = 0;
   int checks = 0;

   always #5 i_clock = ~i_clock;

   mem_stage dut (
      .i_clock            (i_clock),
      .i_reset            (i_reset),
      .i_MEM_enable       (i_MEM_enable),
      .i_MEM_reg_write    (i_MEM_reg_write),
      .i_MEM_mem_to_reg   (i_MEM_mem_to_reg),
      .i_MEM_mem_read     (i_MEM_mem_read),
      .i_MEM_mem_write    (i_MEM_mem_write),
      .i_MEM_size         (i_MEM_size),
      .i_MEM_unsigned     (i_MEM_unsigned),
      .i_MEM_alu_result   (i_MEM_alu_result),
      .i_MEM_write_data   (i_MEM_write_data),
      .i_MEM_selected_reg (i_MEM_selected_reg),
      .i_MEM_r31_ctrl     (i_MEM_r31_ctrl),
      .i_MEM_pc           (i_MEM_pc),
      .i_MEM_halt         (i_MEM_halt),
      .i_MEM_debug_addr   (i_MEM_debug_addr),
      .o_MEM_debug_data   (o_MEM_debug_data),
      .o_WB_reg_write     (o_WB_reg_write),
      .o_WB_mem_to_reg    (o_WB_mem_to_reg),
      .o_WB_r31_ctrl      (o_WB_r31_ctrl),
      .o_WB_halt          (o_WB_halt),
      .o_WB_mem_data      (o_WB_mem_data),
      .o_WB_alu_result    (o_WB_alu_result),
      .o_WB_selected_reg  (o_WB_selected_reg),
      .o_WB_pc            (o_WB_pc)
   );

   task automatic cycle();
      @(posedge i_clock);
      #1;
   endtask

   task automatic drv(input logic rw, input logic m2r, input logic rd, input logic wr,
                      input logic [1:0] sz, input logic uns, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [4:0] rg, input logic r31,
                      input logic [31:0] pc, input logic hlt);
      i_MEM_reg_write    = rw;
      i_MEM_mem_to_reg   = m2r;
      i_MEM_mem_read     = rd;
      i_MEM_mem_write    = wr;
      i_MEM_size         = sz;
      i_MEM_unsigned     = uns;
      i_MEM_alu_result   = alu;
      i_MEM_write_data   = wd;
      i_MEM_selected_reg = rg;
      i_MEM_r31_ctrl     = r31;
      i_MEM_pc           = pc;
      i_MEM_halt         = hlt;
      $display("txn t=%0t en=%0b rd=%0b wr=%0b size=%0d uns=%0b addr=%h data=%h",
               $time, i_MEM_enable, rd, wr, sz, uns, alu, wd);
   endtask

   task automatic test_reset();
      i_reset      = 1'b1;
      i_MEM_enable = 1'b1;
      i_MEM_debug_addr = 8'd0;
      drv(1, 1, 0, 0, SIZE_WORD, 0, 32'h1234_5678, 32'h0, 5'd7, 1, 32'h100, 1);
      #3 i_reset = 1'b0;
      #1;
      checks++;
      if ({o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_halt} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0000",
                  {o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_halt});
      end
      checks++;
      if ({o_WB_mem_data, o_WB_alu_result, o_WB_selected_reg, o_WB_pc} !== '0) begin
         errors++;
         $display("FAIL reset_data: got mem=%h alu=%h reg=%0d pc=%h expected all 0",
                  o_WB_mem_data, o_WB_alu_result, o_WB_selected_reg, o_WB_pc);
      end
      cycle();
      checks++;
      if (o_WB_alu_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_hold_edge: got alu=%h expected 00000000", o_WB_alu_result);
      end
      @(negedge i_clock);
      i_reset = 1'b1;
      cycle();
      checks++;
      if ({o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_halt} !== 4'b1111) begin
         errors++;
         $display("FAIL release_ctrl: got %b expected 1111",
                  {o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_halt});
      end
      checks++;
      if (o_WB_alu_result !== 32'h1234_5678 || o_WB_selected_reg !== 5'd7 ||
          o_WB_pc !== 32'h100 || o_WB_mem_data !== 32'h0) begin
         errors++;
         $display("FAIL release_data: got alu=%h reg=%0d pc=%h mem=%h expected 12345678 7 00000100 00000000",
                  o_WB_alu_result, o_WB_selected_reg, o_WB_pc, o_WB_mem_data);
      end
   endtask

   task automatic test_word();
      drv(0, 0, 0, 1, SIZE_WORD, 0, 32'h10, 32'hDEAD_BEEF, 5'd2, 0, 32'h0, 0);
      cycle();
      i_MEM_debug_addr = 8'd4;
      #1;
      checks++;
      if (o_MEM_debug_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL sw_debug: got %h expected deadbeef", o_MEM_debug_data);
      end
      drv(1, 1, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0, 5'd3, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'hDEAD_BEEF || o_WB_alu_result !== 32'h10 ||
          o_WB_selected_reg !== 5'd3) begin
         errors++;
         $display("FAIL lw: got mem=%h alu=%h reg=%0d expected deadbeef 00000010 3",
                  o_WB_mem_data, o_WB_alu_result, o_WB_selected_reg);
      end
   endtask

   task automatic test_byte();
      drv(0, 0, 0, 1, SIZE_WORD, 0, 32'h10, 32'h0, 5'd0, 0, 32'h0, 0);
      cycle();
      drv(0, 0, 0, 1, SIZE_BYTE, 0, 32'h13, 32'hAAAA_AA80, 5'd0, 0, 32'h0, 0);
      cycle();
      i_MEM_debug_addr = 8'd4;
      #1;
      checks++;
      if (o_MEM_debug_data !== 32'h8000_0000) begin
         errors++;
         $display("FAIL sb_debug: got %h expected 80000000", o_MEM_debug_data);
      end
      drv(1, 1, 1, 0, SIZE_BYTE, 0, 32'h13, 32'h0, 5'd4, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL lb: got %h expected ffffff80", o_WB_mem_data);
      end
      drv(1, 1, 1, 0, SIZE_BYTE, 1, 32'h13, 32'h0, 5'd4, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'h0000_0080) begin
         errors++;
         $display("FAIL lbu: got %h expected 00000080", o_WB_mem_data);
      end
      drv(1, 1, 1, 0, SIZE_BYTE, 0, 32'h12, 32'h0, 5'd4, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'h0000_0000) begin
         errors++;
         $display("FAIL lb_lane2: got %h expected 00000000", o_WB_mem_data);
      end
   endtask

   task automatic test_half();
      drv(0, 0, 0, 1, SIZE_WORD, 0, 32'h20, 32'h0, 5'd0, 0, 32'h0, 0);
      cycle();
      drv(0, 0, 0, 1, SIZE_HALF, 0, 32'h22, 32'h1234_F00D, 5'd0, 0, 32'h0, 0);
      cycle();
      i_MEM_debug_addr = 8'd8;
      #1;
      checks++;
      if (o_MEM_debug_data !== 32'hF00D_0000) begin
         errors++;
         $display("FAIL sh_debug: got %h expected f00d0000", o_MEM_debug_data);
      end
      drv(1, 1, 1, 0, SIZE_HALF, 0, 32'h23, 32'h0, 5'd5, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'hFFFF_F00D) begin
         errors++;
         $display("FAIL lh_forced: got %h expected fffff00d", o_WB_mem_data);
      end
      drv(1, 1, 1, 0, SIZE_HALF, 1, 32'h23, 32'h0, 5'd5, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'h0000_F00D) begin
         errors++;
         $display("FAIL lhu: got %h expected 0000f00d", o_WB_mem_data);
      end
      drv(1, 1, 1, 0, SIZE_HALF, 0, 32'h20, 32'h0, 5'd5, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'h0000_0000) begin
         errors++;
         $display("FAIL lh_low: got %h expected 00000000", o_WB_mem_data);
      end
   endtask

   task automatic test_freeze();
      drv(0, 0, 0, 1, SIZE_WORD, 0, 32'h30, 32'h0, 5'd1, 0, 32'h0, 0);
      cycle();
      i_MEM_enable = 1'b0;
      drv(1, 0, 0, 1, SIZE_WORD, 0, 32'h30, 32'h55, 5'd9, 0, 32'h99, 0);
      cycle();
      i_MEM_debug_addr = 8'd12;
      #1;
      checks++;
      if (o_MEM_debug_data !== 32'h0) begin
         errors++;
         $display("FAIL freeze_mem: got %h expected 00000000", o_MEM_debug_data);
      end
      checks++;
      if (o_WB_pc !== 32'h0 || o_WB_selected_reg !== 5'd1 || o_WB_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL freeze_latch: got pc=%h reg=%0d rw=%b expected 00000000 1 0",
                  o_WB_pc, o_WB_selected_reg, o_WB_reg_write);
      end
      i_MEM_enable = 1'b1;
      cycle();
      checks++;
      if (o_MEM_debug_data !== 32'h55) begin
         errors++;
         $display("FAIL unfreeze_mem: got %h expected 00000055", o_MEM_debug_data);
      end
      checks++;
      if (o_WB_pc !== 32'h99 || o_WB_selected_reg !== 5'd9 || o_WB_reg_write !== 1'b1) begin
         errors++;
         $display("FAIL unfreeze_latch: got pc=%h reg=%0d rw=%b expected 00000099 9 1",
                  o_WB_pc, o_WB_selected_reg, o_WB_reg_write);
      end
   endtask

   task automatic test_link();
      drv(1, 0, 0, 0, SIZE_WORD, 0, 32'h0, 32'h0, 5'd31, 1, 32'h40, 1);
      cycle();
      checks++;
      if (o_WB_pc !== 32'h40 || o_WB_selected_reg !== 5'd31 || o_WB_halt !== 1'b1 ||
          o_WB_r31_ctrl !== 1'b1) begin
         errors++;
         $display("FAIL link: got pc=%h reg=%0d halt=%b r31=%b expected 00000040 31 1 1",
                  o_WB_pc, o_WB_selected_reg, o_WB_halt, o_WB_r31_ctrl);
      end
   endtask

   task automatic test_corner();
      // Reserved size code stores a full word; high address bits ignored on load.
      drv(0, 0, 0, 1, SIZE_RSVD, 0, 32'h40, 32'hCAFE_F00D, 5'd0, 0, 32'h0, 0);
      cycle();
      i_MEM_debug_addr = 8'd16;
      #1;
      checks++;
      if (o_MEM_debug_data !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL rsvd_store: got %h expected cafef00d", o_MEM_debug_data);
      end
      drv(1, 1, 1, 0, SIZE_WORD, 0, 32'h440, 32'h0, 5'd6, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL high_addr_ignored: got %h expected cafef00d", o_WB_mem_data);
      end
      // Read and write together: store happens, latched data is the old word.
      drv(1, 1, 1, 1, SIZE_WORD, 0, 32'h40, 32'h7777_7777, 5'd6, 0, 32'h0, 0);
      cycle();
      checks++;
      if (o_WB_mem_data !== 32'hCAFE_F00D || o_MEM_debug_data !== 32'h7777_7777) begin
         errors++;
         $display("FAIL rd_wr_both: got load=%h mem=%h expected cafef00d 77777777",
                  o_WB_mem_data, o_MEM_debug_data);
      end
      // Debug shows the old word until the storing edge.
      drv(0, 0, 0, 1, SIZE_WORD, 0, 32'h44, 32'h0, 5'd0, 0, 32'h0, 0);
      cycle();
      drv(0, 0, 0, 1, SIZE_WORD, 0, 32'h44, 32'hA5A5_A5A5, 5'd0, 0, 32'h0, 0);
      i_MEM_debug_addr = 8'd17;
      #1;
      checks++;
      if (o_MEM_debug_data !== 32'h0) begin
         errors++;
         $display("FAIL debug_before_edge: got %h expected 00000000", o_MEM_debug_data);
      end
      cycle();
      checks++;
      if (o_MEM_debug_data !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL debug_after_edge: got %h expected a5a5a5a5", o_MEM_debug_data);
      end
   endtask

   task automatic test_reset_store();
      // Word 4 holds 80000000 from the byte test; a store under reset must not land.
      drv(0, 0, 0, 1, SIZE_WORD, 0, 32'h10, 32'h1111_1111, 5'd0, 0, 32'h0, 0);
      i_reset = 1'b0;
      cycle();
      @(negedge i_clock);
      drv(0, 0, 0, 0, SIZE_WORD, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0);
      i_reset = 1'b1;
      i_MEM_debug_addr = 8'd4;
      #1;
      checks++;
      if (o_MEM_debug_data !== 32'h8000_0000) begin
         errors++;
         $display("FAIL reset_blocks_store: got %h expected 80000000", o_MEM_debug_data);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_freeze();
      test_link();
      test_corner();
      test_reset_store();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
